// File: rtl/vga_timing_pkg.sv
// Shared 640x480@60 timing constants for the VGA timing generator and the
// image generator (FRAME_WIDTH / FRAME_HEIGHT), plus the counter and
// colour types used across the slice.
package vga_timing_pkg;

  localparam int unsigned H_VISIBLE = 640;
  localparam int unsigned H_FRONT   = 16;
  localparam int unsigned H_SYNC    = 96;
  localparam int unsigned H_BACK    = 48;
  localparam int unsigned H_TOTAL   = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;

  localparam int unsigned V_VISIBLE = 480;
  localparam int unsigned V_FRONT   = 10;
  localparam int unsigned V_SYNC    = 2;
  localparam int unsigned V_BACK    = 33;
  localparam int unsigned V_TOTAL   = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

  localparam int unsigned H_SYNC_START = H_VISIBLE + H_FRONT;
  localparam int unsigned H_SYNC_END   = H_SYNC_START + H_SYNC - 1;
  localparam int unsigned V_SYNC_START = V_VISIBLE + V_FRONT;
  localparam int unsigned V_SYNC_END   = V_SYNC_START + V_SYNC - 1;

  localparam int unsigned FRAME_WIDTH  = H_VISIBLE;
  localparam int unsigned FRAME_HEIGHT = V_VISIBLE;

  localparam int unsigned CNT_W = 12;
  typedef logic [CNT_W-1:0] cnt_t;

  typedef struct packed {
    logic r;
    logic g;
    logic b;
  } rgb_t;

endpackage

// File: rtl/vga_timing_if.sv
// Bundle between the timing generator and the image generator / pins.
//   color       : pixel colour for the current (x,y), driven by the image generator
//   x, y        : registered raster counters
//   vga_hsync/vsync, vga_r/g/b : registered pin drive, one cycle behind x,y
//   active      : (x,y) lies in the visible area
//   frame_tick  : one-cycle pulse at the last visible pixel of a frame
// master = timing generator, slave = image generator / consumer.
interface vga_timing_if;
  import vga_timing_pkg::*;

  logic [2:0] color;
  cnt_t       x;
  cnt_t       y;
  logic       vga_hsync;
  logic       vga_vsync;
  logic       vga_r;
  logic       vga_g;
  logic       vga_b;
  logic       active;
  logic       frame_tick;

  modport master (
    input  color,
    output x, y, vga_hsync, vga_vsync, vga_r, vga_g, vga_b, active, frame_tick
  );

  modport slave (
    output color,
    input  x, y, vga_hsync, vga_vsync, vga_r, vga_g, vga_b, active, frame_tick
  );
endinterface

// File: rtl/vga_timing.sv
// VGA raster timing generator.
//   CLOCK_25 : pixel clock
//   reset    : synchronous, active-high
//   vga      : vga_timing_if master (counters, syncs, colour drive, active, frame_tick)
// Horizontal/vertical counters run inline; syncs and colour are registered
// from the previous cycle's counters so all pin outputs share one cycle of
// latency. Timing parameters default to the shared package values.
module vga_timing
  import vga_timing_pkg::*;
#(
  parameter int unsigned H_VIS = H_VISIBLE,
  parameter int unsigned H_FP  = H_FRONT,
  parameter int unsigned H_SW  = H_SYNC,
  parameter int unsigned H_BP  = H_BACK,
  parameter int unsigned V_VIS = V_VISIBLE,
  parameter int unsigned V_FP  = V_FRONT,
  parameter int unsigned V_SW  = V_SYNC,
  parameter int unsigned V_BP  = V_BACK
) (
  input  logic         CLOCK_25,
  input  logic         reset,
  vga_timing_if.master vga
);

  localparam cnt_t H_LAST     = cnt_t'(H_VIS + H_FP + H_SW + H_BP - 1);
  localparam cnt_t V_LAST     = cnt_t'(V_VIS + V_FP + V_SW + V_BP - 1);
  localparam cnt_t H_VIS_C    = cnt_t'(H_VIS);
  localparam cnt_t V_VIS_C    = cnt_t'(V_VIS);
  localparam cnt_t H_VIS_LAST = cnt_t'(H_VIS - 1);
  localparam cnt_t V_VIS_LAST = cnt_t'(V_VIS - 1);
  localparam cnt_t HS_START   = cnt_t'(H_VIS + H_FP);
  localparam cnt_t HS_END     = cnt_t'(H_VIS + H_FP + H_SW - 1);
  localparam cnt_t VS_START   = cnt_t'(V_VIS + V_FP);
  localparam cnt_t VS_END     = cnt_t'(V_VIS + V_FP + V_SW - 1);

  cnt_t x;
  cnt_t y;
  logic x_wrap;
  logic y_wrap;
  logic active;
  logic frame_tick;
  logic hsync_q;
  logic vsync_q;
  rgb_t rgb_q;

  always_comb begin
    // >= rather than == so an out-of-range value can never persist
    x_wrap     = (x >= H_LAST);
    y_wrap     = (y >= V_LAST);
    active     = (x < H_VIS_C) && (y < V_VIS_C);
    frame_tick = !reset && (x == H_VIS_LAST) && (y == V_VIS_LAST);
  end

  always_ff @(posedge CLOCK_25) begin
    if (reset) begin
      x       <= '0;
      y       <= '0;
      hsync_q <= 1'b1;
      vsync_q <= 1'b1;
      rgb_q   <= '0;
    end else begin
      x <= x_wrap ? '0 : x + cnt_t'(1);
      if (x_wrap) begin
        y <= y_wrap ? '0 : y + cnt_t'(1);
      end
      hsync_q <= !((x >= HS_START) && (x <= HS_END));
      vsync_q <= !((y >= VS_START) && (y <= VS_END));
      rgb_q   <= active ? rgb_t'(vga.color) : '0;
    end
  end

  assign vga.x          = x;
  assign vga.y          = y;
  assign vga.active     = active;
  assign vga.frame_tick = frame_tick;
  assign vga.vga_hsync  = hsync_q;
  assign vga.vga_vsync  = vsync_q;
  assign vga.vga_r      = rgb_q.r;
  assign vga.vga_g      = rgb_q.g;
  assign vga.vga_b      = rgb_q.b;

endmodule

// File: tb/tb_vga_timing.sv
// Self-checking bench for vga_timing. dut_a uses the full 640x480 timing;
// dut_b keeps the full horizontal timing but a 10-line frame so vertical
// sync, frame_tick and the frame wrap are reachable in a short run.
module tb_vga_timing;

  localparam int unsigned HV = 640;
  localparam int unsigned HF = 16;
  localparam int unsigned HS = 96;
  localparam int unsigned HT = 800;
  localparam int unsigned BV = 4;
  localparam int unsigned BF = 2;
  localparam int unsigned BS = 2;
  localparam int unsigned BB = 2;
  localparam int unsigned BT = BV + BF + BS + BB;

  typedef struct packed {
    logic       hs;
    logic       vs;
    logic [2:0] rgb;
  } out_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int unsigned tests = 0;
  int unsigned fails = 0;
  out_t sb_q[$];

  always #5 clk = ~clk;

  vga_timing_if va();
  vga_timing_if vb();

  vga_timing dut_a (
    .CLOCK_25 (clk),
    .reset    (rst),
    .vga      (va)
  );

  vga_timing #(
    .V_VIS (BV),
    .V_FP  (BF),
    .V_SW  (BS),
    .V_BP  (BB)
  ) dut_b (
    .CLOCK_25 (clk),
    .reset    (rst),
    .vga      (vb)
  );

  // Expected pin outputs one cycle after the counters sit at (x,y).
  function automatic out_t model(int unsigned x, int unsigned y,
                                 int unsigned vvis, int unsigned vs0,
                                 logic [2:0] c);
    out_t o;
    o.hs  = !(x >= HV + HF && x < HV + HF + HS);
    o.vs  = !(y >= vs0 && y < vs0 + 2);
    o.rgb = (x < HV && y < vvis) ? c : 3'b000;
    return o;
  endfunction

  task automatic do_reset(int unsigned n);
    @(negedge clk);
    rst = 1'b1;
    repeat (n) @(negedge clk);
    rst = 1'b0;
    sb_q.delete();
  endtask

  task automatic test_reset();
    va.color = 3'b111;
    vb.color = 3'b111;
    do_reset(5);
    tests++;
    if (va.x !== 12'd0 || va.y !== 12'd0) begin
      fails++; $display("FAIL reset_xy got x=%0d y=%0d required 0 0", va.x, va.y);
    end
    tests++;
    if ({va.vga_hsync, va.vga_vsync} !== 2'b11) begin
      fails++; $display("FAIL reset_sync got %b required 11", {va.vga_hsync, va.vga_vsync});
    end
    tests++;
    if ({va.vga_r, va.vga_g, va.vga_b} !== 3'b000) begin
      fails++; $display("FAIL reset_rgb got %b required 000", {va.vga_r, va.vga_g, va.vga_b});
    end
    tests++;
    if (va.frame_tick !== 1'b0 || va.active !== 1'b1) begin
      fails++; $display("FAIL reset_tick_active got %b%b required 01", va.frame_tick, va.active);
    end
    @(negedge clk);
    tests++;
    if (va.x !== 12'd1 || va.y !== 12'd0) begin
      fails++; $display("FAIL release_x got x=%0d y=%0d required 1 0", va.x, va.y);
    end
    tests++;
    if ({va.vga_r, va.vga_g, va.vga_b} !== 3'b111) begin
      fails++; $display("FAIL first_pixel got %b required 111", {va.vga_r, va.vga_g, va.vga_b});
    end
  endtask

  task automatic test_line();
    int unsigned mx = 0, my = 0, lows = 0, first_low = 0;
    out_t got, exp;
    va.color = 3'b000;
    do_reset(2);
    for (int unsigned c = 0; c <= HT; c++) begin
      got = {va.vga_hsync, va.vga_vsync, va.vga_r, va.vga_g, va.vga_b};
      tests++;
      if (va.x !== 12'(mx) || va.y !== 12'(my)) begin
        fails++; $display("FAIL line_xy c=%0d got %0d,%0d required %0d,%0d", c, va.x, va.y, mx, my);
      end
      if (sb_q.size() > 0) begin
        exp = sb_q.pop_front();
        tests++;
        if (got !== exp) begin
          fails++; $display("FAIL line_out c=%0d got %b required %b", c, got, exp);
        end
      end
      if (!got.hs) begin
        if (lows == 0) first_low = c;
        lows++;
      end
      sb_q.push_back(model(mx, my, 480, 490, va.color));
      mx++;
      if (mx == HT) begin mx = 0; my++; end
      @(negedge clk);
    end
    tests++;
    if (lows != HS || first_low != HV + HF + 1) begin
      fails++; $display("FAIL hsync_pulse got len=%0d start=%0d required %0d %0d", lows, first_low, HS, HV + HF + 1);
    end
  endtask

  task automatic test_color();
    int unsigned mx = 0, my = 0, lit = 0;
    out_t got, exp;
    vb.color = 3'b101;
    do_reset(2);
    for (int unsigned c = 0; c <= BT * HT; c++) begin
      got = {vb.vga_hsync, vb.vga_vsync, vb.vga_r, vb.vga_g, vb.vga_b};
      if (sb_q.size() > 0) begin
        exp = sb_q.pop_front();
        tests++;
        if (got !== exp) begin
          fails++; $display("FAIL color_out c=%0d got %b required %b", c, got, exp);
        end
      end
      if (got.rgb == 3'b101) lit++;
      sb_q.push_back(model(mx, my, BV, BV + BF, vb.color));
      mx++;
      if (mx == HT) begin mx = 0; my = (my == BT - 1) ? 0 : my + 1; end
      @(negedge clk);
    end
    tests++;
    if (lit != HV * BV) begin
      fails++; $display("FAIL color_count got %0d required %0d", lit, HV * BV);
    end
  endtask

  task automatic test_frame();
    int unsigned mx = 0, my = 0, vlows = 0, vfirst = 0;
    int unsigned tick_at[$];
    out_t got, exp;
    vb.color = 3'b010;
    do_reset(3);
    for (int unsigned c = 0; c <= 2 * BT * HT; c++) begin
      got = {vb.vga_hsync, vb.vga_vsync, vb.vga_r, vb.vga_g, vb.vga_b};
      tests++;
      if (vb.x !== 12'(mx) || vb.y !== 12'(my)) begin
        fails++; $display("FAIL frame_xy c=%0d got %0d,%0d required %0d,%0d", c, vb.x, vb.y, mx, my);
      end
      tests++;
      if (vb.frame_tick !== (mx == HV - 1 && my == BV - 1)) begin
        fails++; $display("FAIL frame_tick c=%0d got %b at %0d,%0d", c, vb.frame_tick, mx, my);
      end
      tests++;
      if (vb.active !== (mx < HV && my < BV)) begin
        fails++; $display("FAIL active c=%0d got %b at %0d,%0d", c, vb.active, mx, my);
      end
      if (sb_q.size() > 0) begin
        exp = sb_q.pop_front();
        tests++;
        if (got !== exp) begin
          fails++; $display("FAIL frame_out c=%0d got %b required %b", c, got, exp);
        end
      end
      if (!got.vs && c <= BT * HT) begin
        if (vlows == 0) vfirst = c;
        vlows++;
      end
      if (vb.frame_tick) tick_at.push_back(c);
      sb_q.push_back(model(mx, my, BV, BV + BF, vb.color));
      mx++;
      if (mx == HT) begin mx = 0; my = (my == BT - 1) ? 0 : my + 1; end
      @(negedge clk);
    end
    tests++;
    if (vlows != BS * HT || vfirst != (BV + BF) * HT + 1) begin
      fails++; $display("FAIL vsync_pulse got len=%0d start=%0d required %0d %0d", vlows, vfirst, BS * HT, (BV + BF) * HT + 1);
    end
    tests++;
    if (tick_at.size() != 2) begin
      fails++; $display("FAIL tick_count got %0d required 2", tick_at.size());
    end else if (tick_at[0] != (BV - 1) * HT + HV - 1 || tick_at[1] - tick_at[0] != BT * HT) begin
      fails++; $display("FAIL tick_period got first=%0d period=%0d required %0d %0d", tick_at[0], tick_at[1] - tick_at[0], (BV - 1) * HT + HV - 1, BT * HT);
    end
  endtask

  task automatic test_wrap();
    vb.color = 3'b001;
    do_reset(2);
    repeat (BT * HT - 1) @(negedge clk);
    tests++;
    if (vb.x !== 12'(HT - 1) || vb.y !== 12'(BT - 1)) begin
      fails++; $display("FAIL wrap_pre got %0d,%0d required %0d,%0d", vb.x, vb.y, HT - 1, BT - 1);
    end
    @(negedge clk);
    tests++;
    if (vb.x !== 12'd0 || vb.y !== 12'd0) begin
      fails++; $display("FAIL wrap_xy got %0d,%0d required 0,0", vb.x, vb.y);
    end
    tests++;
    if (vb.vga_vsync !== 1'b1 || vb.active !== 1'b1) begin
      fails++; $display("FAIL wrap_vs_active got %b%b required 11", vb.vga_vsync, vb.active);
    end
  endtask

  task automatic test_mid_reset();
    do_reset(2);
    repeat ((BV + BF) * HT + 700) @(negedge clk);
    tests++;
    if (va.x !== 12'd700 || va.vga_hsync !== 1'b0 || vb.vga_vsync !== 1'b0) begin
      fails++; $display("FAIL midrst_pre got x=%0d hs=%b vs=%b required 700 0 0", va.x, va.vga_hsync, vb.vga_vsync);
    end
    rst = 1'b1;
    @(negedge clk);
    tests++;
    if (va.x !== 12'd0 || va.y !== 12'd0 || vb.x !== 12'd0 || vb.y !== 12'd0) begin
      fails++; $display("FAIL midrst_xy got a=%0d,%0d b=%0d,%0d required zeros", va.x, va.y, vb.x, vb.y);
    end
    tests++;
    if ({va.vga_hsync, vb.vga_hsync, vb.vga_vsync} !== 3'b111) begin
      fails++; $display("FAIL midrst_sync got %b required 111", {va.vga_hsync, vb.vga_hsync, vb.vga_vsync});
    end
    rst = 1'b0;
    for (int unsigned c = 0; c <= HV + HF; c++) begin
      tests++;
      if (va.vga_hsync !== 1'b1 || vb.vga_vsync !== 1'b1) begin
        fails++; $display("FAIL midrst_residual c=%0d got hs=%b vs=%b required 1 1", c, va.vga_hsync, vb.vga_vsync);
      end
      @(negedge clk);
    end
    tests++;
    if (va.vga_hsync !== 1'b0) begin
      fails++; $display("FAIL midrst_next_pulse got %b required 0", va.vga_hsync);
    end
  endtask

  initial begin
    va.color = 3'b000;
    vb.color = 3'b000;
    test_reset();
    test_line();
    test_color();
    test_frame();
    test_wrap();
    test_mid_reset();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog run exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
